// File: rtl/spi_arbiter_24.sv
// -----------------------------------------------------------------------------
// spi_arbiter_24
//   Round-robin arbiter that shares one free-running 24-bit SPI shifter among
//   three requesters. A granted frame is strobed into the shifter. Completion is
//   taken from the shifter's DONE rising edge, or forced by a timeout. Each
//   transaction is followed by a guard gap with the shifter's CS idle.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   req_i[2:0]     level-sensitive transaction requests
//   tx0_i..tx2_i   requester frames {ctrl, reg, data}
//   ack_o[2:0]     one-cycle completion pulse for the granted requester
//   err_o[2:0]     timeout flag, coincident with ack_o
//   rx_data_o      received frame, valid in the ACK cycle, held until next ACK
//   busy_o         high from grant until entry to the gap
//   sh_start_o     start strobe to the shifter (START_HOLD cycles)
//   sh_data_out_o  frame presented to the shifter, stable for the transaction
//   sh_done_i      shifter done level (rising edge used)
//   sh_cs_i        shifter chip select, active-low
//   sh_data_in_i   shifter receive frame
//   cs_n_o[2:0]    per-device chip selects, active-low
// -----------------------------------------------------------------------------
module spi_arbiter_24 #(
  parameter logic [7:0]  START_HOLD = 8'd4,
  parameter logic [15:0] GAP_CYCLES = 16'd128,  // must cover the shifter's post-CS DONE delay
  parameter logic [23:0] TIMEOUT    = 24'd100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  req_i,
  input  logic [23:0] tx0_i,
  input  logic [23:0] tx1_i,
  input  logic [23:0] tx2_i,
  output logic [2:0]  ack_o,
  output logic [2:0]  err_o,
  output logic [23:0] rx_data_o,
  output logic        busy_o,
  output logic        sh_start_o,
  output logic [23:0] sh_data_out_o,
  input  logic        sh_done_i,
  input  logic        sh_cs_i,
  input  logic [23:0] sh_data_in_i,
  output logic [2:0]  cs_n_o
);

  typedef enum logic [2:0] {
    S_GAP,
    S_IDLE,
    S_START,
    S_BUSY,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  start_cnt_q, start_cnt_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [23:0] sh_data_q, sh_data_d;
  logic [23:0] rx_data_q, rx_data_d;
  logic        err_q, err_d;
  logic        done_s1_q, done_s2_q;
  logic        done_re;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [23:0] pick_tx;
  logic [1:0]  rr1, rr2;

  // (base + ofs) mod 3 for base, ofs in 0..2
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] ofs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  assign done_re = done_s1_q & ~done_s2_q;

  // Round-robin pick: first requester at or after the pointer wins.
  assign rr1 = rr_idx(ptr_q, 2'd1);
  assign rr2 = rr_idx(ptr_q, 2'd2);

  always_comb begin
    pick_valid = 1'b1;
    pick_idx   = ptr_q;
    if (req_i[ptr_q])    pick_idx = ptr_q;
    else if (req_i[rr1]) pick_idx = rr1;
    else if (req_i[rr2]) pick_idx = rr2;
    else                 pick_valid = 1'b0;
  end

  always_comb begin
    case (pick_idx)
      2'd1:    pick_tx = tx1_i;
      2'd2:    pick_tx = tx2_i;
      default: pick_tx = tx0_i;
    endcase
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    start_cnt_d = start_cnt_q;
    to_cnt_d    = to_cnt_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    sh_data_d   = sh_data_q;
    rx_data_d   = rx_data_q;
    err_d       = err_q;

    case (state_q)
      S_GAP: begin
        // Only consecutive idle-CS cycles count; any CS activity restarts.
        if (!sh_cs_i) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q >= GAP_CYCLES - 16'd1) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      S_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_idx;
          sh_data_d   = pick_tx;
          start_cnt_d = '0;
          to_cnt_d    = '0;
          state_d     = S_START;
        end
      end

      S_START: begin
        // Timeout runs from the first strobe cycle.
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 24'd1;
        if (start_cnt_q >= START_HOLD - 8'd1) begin
          state_d = S_BUSY;
        end else if (start_cnt_q != '1) begin
          start_cnt_d = start_cnt_q + 8'd1;
        end
      end

      S_BUSY: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 24'd1;
        // A real completion beats a timeout expiring in the same cycle.
        if (done_re) begin
          rx_data_d = sh_data_in_i;
          err_d     = 1'b0;
          state_d   = S_ACK;
        end else if (to_cnt_q >= TIMEOUT - 24'd1) begin
          rx_data_d = '0;
          err_d     = 1'b1;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        ptr_d     = rr_idx(grant_q, 2'd1);
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end

      default: state_d = S_GAP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_GAP;
      gap_cnt_q   <= '0;
      start_cnt_q <= '0;
      to_cnt_q    <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      sh_data_q   <= '0;
      rx_data_q   <= '0;
      err_q       <= 1'b0;
      done_s1_q   <= 1'b0;
      done_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      start_cnt_q <= start_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      sh_data_q   <= sh_data_d;
      rx_data_q   <= rx_data_d;
      err_q       <= err_d;
      done_s1_q   <= sh_done_i;
      done_s2_q   <= done_s1_q;
    end
  end

  // Outputs are decoded from state so a reset clears them on the same edge.
  assign sh_start_o    = (state_q == S_START);
  assign busy_o        = (state_q == S_START) || (state_q == S_BUSY) || (state_q == S_ACK);
  assign ack_o         = (state_q == S_ACK) ? (3'b001 << grant_q) : 3'b000;
  assign err_o         = (state_q == S_ACK && err_q) ? (3'b001 << grant_q) : 3'b000;
  assign rx_data_o     = rx_data_q;
  assign sh_data_out_o = sh_data_q;

  // Only the granted device sees the shifter's CS, combinationally.
  always_comb begin
    cs_n_o = 3'b111;
    if (state_q == S_START || state_q == S_BUSY) cs_n_o[grant_q] = sh_cs_i;
  end

endmodule

// File: tb/tb_spi_arbiter_24.sv
module tb_spi_arbiter_24;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  req_i;
  logic [23:0] tx0_i, tx1_i, tx2_i;
  logic [2:0]  ack_o, err_o;
  logic [23:0] rx_data_o;
  logic        busy_o;
  logic        sh_start_o;
  logic [23:0] sh_data_out_o;
  logic        sh_done_i;
  logic        sh_cs_i;
  logic [23:0] sh_data_in_i;
  logic [2:0]  cs_n_o;

  spi_arbiter_24 #(
    .START_HOLD(8'd4),
    .GAP_CYCLES(16'd128),
    .TIMEOUT   (24'd1000)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .tx0_i        (tx0_i),
    .tx1_i        (tx1_i),
    .tx2_i        (tx2_i),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rx_data_o    (rx_data_o),
    .busy_o       (busy_o),
    .sh_start_o   (sh_start_o),
    .sh_data_out_o(sh_data_out_o),
    .sh_done_i    (sh_done_i),
    .sh_cs_i      (sh_cs_i),
    .sh_data_in_i (sh_data_in_i),
    .cs_n_o       (cs_n_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Shifter model: free-running once strobed, works on the falling edge.
  logic [23:0] rx_val  = '0;
  bit          done_en = 1'b1;

  initial begin
    forever begin
      @(negedge clk_i);
      if (sh_start_o === 1'b1) begin
        while (sh_start_o === 1'b1) @(negedge clk_i);
        sh_cs_i = 1'b0;
        repeat (20) @(negedge clk_i);
        sh_cs_i = 1'b1;
        repeat (5) @(negedge clk_i);
        if (done_en) begin
          sh_data_in_i = rx_val;
          sh_done_i    = 1'b1;
        end
        repeat (3) @(negedge clk_i);
        sh_done_i = 1'b0;
      end
    end
  end

  // Continuous monitors, summarised by checks at the end.
  bit cs_overlap = 1'b0;
  bit ack_bad    = 1'b0;
  int ack_count  = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      if ($countones(~cs_n_o) > 1) cs_overlap = 1'b1;
      if (ack_o != 3'b000) ack_count++;
      if ($countones(ack_o) > 1 || (err_o & ~ack_o) != 3'b000) ack_bad = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_start(output int gap_run, output bit ok);
    gap_run = 0;
    ok      = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      gap_run = sh_cs_i ? gap_run + 1 : 0;
      if (sh_start_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (sh_cs_i == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      cycles++;
      if (ack_o != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [23:0] tx0, tx1, tx2;
    logic [23:0] rx;
    logic [2:0]  exp_ack;
    logic [23:0] exp_data;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int         gap_run, hold, cyc;
    bit         ok;
    logic [2:0] exp_csn;
    exp_csn = ~v.exp_ack;
    req_i = v.req;
    tx0_i = v.tx0;
    tx1_i = v.tx1;
    tx2_i = v.tx2;
    rx_val = v.rx;
    wait_start(gap_run, ok);
    check({tag, " start seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({tag, " gap>=128"}, 32'(gap_run >= 128), 32'd1);
    check({tag, " sh_data_out"}, 32'(sh_data_out_o), 32'(v.exp_data));
    check({tag, " busy"}, 32'(busy_o), 32'd1);
    hold = 0;
    while (sh_start_o && hold < 50) begin
      hold++;
      tick();
    end
    check({tag, " start hold"}, 32'(hold), 32'd4);
    wait_cs(1'b0, ok);
    check({tag, " cs low"}, 32'(ok), 32'd1);
    check({tag, " cs_n active"}, 32'(cs_n_o), 32'(exp_csn));
    wait_cs(1'b1, ok);
    check({tag, " cs_n idle"}, 32'(cs_n_o), 32'h7);
    wait_ack(cyc, ok);
    check({tag, " ack seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({tag, " ack"}, 32'(ack_o), 32'(v.exp_ack));
    check({tag, " err"}, 32'(err_o), 32'd0);
    check({tag, " rx_data"}, 32'(rx_data_o), 32'(v.rx));
    tick();
    check({tag, " ack one cycle"}, 32'(ack_o), 32'd0);
    check({tag, " rx hold"}, 32'(rx_data_o), 32'(v.rx));
  endtask

  vec_t vecs[8];

  initial begin
    int         gap_run, cyc, acks_before, starts;
    bit         ok;
    logic [2:0] rr_exp[5];

    // Pointer walk: 0 ->1 ->1 ->2 ->0 ->1 ->0 ->2 ->1
    vecs[0] = '{3'b001, 24'h4A12FF, 24'h111111, 24'h222222, 24'h0000A5, 3'b001, 24'h4A12FF};
    vecs[1] = '{3'b001, 24'h0F0F0F, 24'hA1A1A1, 24'hB2B2B2, 24'h123456, 3'b001, 24'h0F0F0F};
    vecs[2] = '{3'b110, 24'hC00001, 24'hC00002, 24'hC00003, 24'h654321, 3'b010, 24'hC00002};
    vecs[3] = '{3'b111, 24'hD00001, 24'hD00002, 24'hD00003, 24'hABCDEF, 3'b100, 24'hD00003};
    vecs[4] = '{3'b111, 24'hE00001, 24'hE00002, 24'hE00003, 24'h00FF00, 3'b001, 24'hE00001};
    vecs[5] = '{3'b101, 24'hF00001, 24'hF00002, 24'hF00003, 24'h5A5A5A, 3'b100, 24'hF00003};
    vecs[6] = '{3'b110, 24'h100001, 24'h100002, 24'h100003, 24'h0A0B0C, 3'b010, 24'h100002};
    vecs[7] = '{3'b011, 24'h200001, 24'h200002, 24'h200003, 24'h7E7E7E, 3'b001, 24'h200001};

    rst_i        = 1'b1;
    req_i        = 3'b000;
    tx0_i        = '0;
    tx1_i        = '0;
    tx2_i        = '0;
    sh_cs_i      = 1'b1;
    sh_done_i    = 1'b0;
    sh_data_in_i = '0;

    // Reset state
    repeat (3) tick();
    check("rst ack", 32'(ack_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst rx_data", 32'(rx_data_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst sh_start", 32'(sh_start_o), 32'd0);
    check("rst sh_data_out", 32'(sh_data_out_o), 32'd0);
    check("rst cs_n", 32'(cs_n_o), 32'h7);
    rst_i = 1'b0;

    // Basic transaction and round-robin table
    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    req_i = 3'b000;

    // Timeout: shifter never reports done
    done_en = 1'b0;
    req_i   = 3'b010;
    tx1_i   = 24'h777777;
    rx_val  = 24'h999999;
    wait_start(gap_run, ok);
    check("to start seen", 32'(ok), 32'd1);
    wait_ack(cyc, ok);
    check("to ack seen", 32'(ok), 32'd1);
    check("to latency", 32'(cyc), 32'd1000);
    check("to ack", 32'(ack_o), 32'h2);
    check("to err", 32'(err_o), 32'h2);
    check("to rx_data", 32'(rx_data_o), 32'd0);
    req_i = 3'b000;
    tick();
    check("to ack clear", 32'(ack_o), 32'd0);
    check("to err clear", 32'(err_o), 32'd0);
    done_en = 1'b1;

    // Reset during BUSY of requester 2
    req_i  = 3'b100;
    tx2_i  = 24'h0C0C0C;
    rx_val = 24'hDEAD01;
    wait_start(gap_run, ok);
    check("mr start seen", 32'(ok), 32'd1);
    wait_cs(1'b0, ok);
    check("mr cs low", 32'(ok), 32'd1);
    check("mr cs_n active", 32'(cs_n_o), 32'h3);
    acks_before = ack_count;
    rst_i = 1'b1;
    tick();
    check("mr cs_n released", 32'(cs_n_o), 32'h7);
    check("mr busy", 32'(busy_o), 32'd0);
    check("mr sh_data_out", 32'(sh_data_out_o), 32'd0);
    rst_i  = 1'b0;
    req_i  = 3'b101;
    tx0_i  = 24'h0A0A0A;
    rx_val = 24'h0000C3;
    wait_start(gap_run, ok);
    check("mr restart seen", 32'(ok), 32'd1);
    check("mr no ack", 32'(ack_count), 32'(acks_before));
    check("mr gap>=128", 32'(gap_run >= 128), 32'd1);
    check("mr ptr reset", 32'(sh_data_out_o), 32'h0A0A0A);
    wait_ack(cyc, ok);
    check("mr ack", 32'(ack_o), 32'h1);
    check("mr rx_data", 32'(rx_data_o), 32'h0000C3);
    req_i = 3'b000;

    // Short REQ pulse and TX change during BUSY
    req_i  = 3'b001;
    tx0_i  = 24'h13579B;
    rx_val = 24'h2468AC;
    wait_start(gap_run, ok);
    check("pl start seen", 32'(ok), 32'd1);
    check("pl sh_data_out", 32'(sh_data_out_o), 32'h13579B);
    wait_cs(1'b0, ok);
    req_i = 3'b011;
    tx0_i = 24'hFFFFFF;
    tick();
    req_i = 3'b001;
    check("pl data stable", 32'(sh_data_out_o), 32'h13579B);
    wait_ack(cyc, ok);
    check("pl ack", 32'(ack_o), 32'h1);
    check("pl rx_data", 32'(rx_data_o), 32'h2468AC);
    req_i  = 3'b000;
    starts = 0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (sh_start_o) starts++;
    end
    check("pl no grant", 32'(starts), 32'd0);

    // All three requesting from reset
    req_i = 3'b111;
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;
    rr_exp[4] = 3'b010;
    for (int k = 0; k < 5; k++) begin
      wait_start(gap_run, ok);
      check($sformatf("rr%0d start seen", k), 32'(ok), 32'd1);
      check($sformatf("rr%0d gap>=128", k), 32'(gap_run >= 128), 32'd1);
      wait_ack(cyc, ok);
      check($sformatf("rr%0d ack", k), 32'(ack_o), 32'(rr_exp[k]));
    end
    req_i = 3'b000;

    check("cs_n never two low", 32'(cs_overlap), 32'd0);
    check("ack/err one-hot", 32'(ack_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
